// File: rtl/midi_voice_allocator_if.sv
// midi_voice_allocator_if: received MIDI byte stream, one byte plus a one-cycle valid strobe.
// The UART receiver side is the master; the voice allocator is the slave.
interface midi_voice_allocator_if;
   logic [7:0] iMidiRd;
   logic       iMidiVd;

   modport master (output iMidiRd, output iMidiVd);
   modport slave  (input  iMidiRd, input  iMidiVd);
endinterface

// File: rtl/midi_voice_allocator.sv
// midi_voice_allocator: channel-voice MIDI parser with running status and oldest-first voice stealing.
// Optional sustain pedal (CC64) handling is built when SYNTH_ALLOC_SUSTAIN_EN is defined.
//
// state   | meaning
// sNoStat | no running status; data bytes are errors (or SysEx payload, silently dropped)
// sData1  | running status valid, waiting for first data byte
// sData2  | first data byte latched, waiting for second
module midi_voice_allocator #(
   parameter int pVoiceNum  = 4,
   parameter int pRankWidth = 2,
   parameter bit pOmni      = 1'b0
) (
   input  logic                   iCLK,
   input  logic                   inRST,
   midi_voice_allocator_if.slave  midiBus,
   input  logic [3:0]             iMidiCh,
   input  logic                   iVoiceClr,
   output logic [pVoiceNum*7-1:0] oVoiceNote,
   output logic [pVoiceNum*7-1:0] oVoiceVel,
   output logic [pVoiceNum-1:0]   oVoiceGate,
   output logic [pVoiceNum-1:0]   oVoiceTrig,
   output logic                   oSteal,
   output logic                   oParseErr
);

   typedef enum logic [1:0] {sNoStat, sData1, sData2} stateT;

   stateT                 state;
   logic [7:0]            runStat;
   logic                  inSysex;
   logic [6:0]            d1Reg;

   logic [6:0]            note [pVoiceNum];
   logic [6:0]            vel  [pVoiceNum];
   logic [pRankWidth-1:0] rank [pVoiceNum];
   logic [pVoiceNum-1:0]  gate;
   logic [pVoiceNum-1:0]  trig;
   logic                  steal;
   logic                  parseErr;

`ifdef SYNTH_ALLOC_SUSTAIN_EN
   logic                  sustain;
   logic [pVoiceNum-1:0]  hold;
   logic                  ccSusEv;
`endif

   logic [7:0]            rd;
   logic                  isData;
   logic                  oneByte;
   logic                  msgDone;
   logic                  chanOk;
   logic                  noteOnEv;
   logic                  noteOffEv;
   logic [6:0]            msgD1;
   logic [6:0]            msgD2;

   assign rd = midiBus.iMidiRd;

   // The completed message is decoded combinationally so voices update on the edge that takes the last byte.
   always_comb begin
      isData    = midiBus.iMidiVd && !rd[7];
      oneByte   = (runStat[7:4] == 4'hC) || (runStat[7:4] == 4'hD);
      msgDone   = isData && (((state == sData1) && oneByte) || (state == sData2));
      msgD1     = (state == sData2) ? d1Reg : rd[6:0];
      msgD2     = (state == sData2) ? rd[6:0] : 7'd0;
      chanOk    = pOmni || (runStat[3:0] == iMidiCh);
      noteOnEv  = msgDone && chanOk && (runStat[7:4] == 4'h9) && (msgD2 != 7'd0);
      noteOffEv = msgDone && chanOk &&
                  ((runStat[7:4] == 4'h8) || ((runStat[7:4] == 4'h9) && (msgD2 == 7'd0)));
   end

`ifdef SYNTH_ALLOC_SUSTAIN_EN
   assign ccSusEv = msgDone && chanOk && (runStat[7:4] == 4'hB) && (msgD1 == 7'd64);
`endif

   logic [pVoiceNum-1:0]  matchVec;
   logic                  anyMatch;
   logic                  anyFree;
   logic [pRankWidth-1:0] matchIdx;
   logic [pRankWidth-1:0] freeIdx;
   logic [pRankWidth-1:0] oldIdx;
   logic [pRankWidth-1:0] chosenIdx;
   logic [pRankWidth-1:0] chosenRank;

   // Descending scan so the lowest matching / free index is the one left standing.
   always_comb begin
      matchVec = '0;
      anyMatch = 1'b0;
      anyFree  = 1'b0;
      matchIdx = '0;
      freeIdx  = '0;
      oldIdx   = '0;
      for (int i = pVoiceNum - 1; i >= 0; i--) begin
         matchVec[i] = gate[i] && (note[i] == msgD1);
         if (matchVec[i]) begin
            anyMatch = 1'b1;
            matchIdx = pRankWidth'(i);
         end
         if (!gate[i]) begin
            anyFree = 1'b1;
            freeIdx = pRankWidth'(i);
         end
         if (rank[i] == pRankWidth'(pVoiceNum - 1)) oldIdx = pRankWidth'(i);
      end
      chosenIdx  = anyMatch ? matchIdx : (anyFree ? freeIdx : oldIdx);
      chosenRank = rank[chosenIdx];
   end

   always_ff @(posedge iCLK or negedge inRST) begin
      if (!inRST) begin
         state    <= sNoStat;
         runStat  <= '0;
         inSysex  <= 1'b0;
         d1Reg    <= '0;
         gate     <= '0;
         trig     <= '0;
         steal    <= 1'b0;
         parseErr <= 1'b0;
         for (int i = 0; i < pVoiceNum; i++) begin
            note[i] <= '0;
            vel[i]  <= '0;
            rank[i] <= pRankWidth'(i);
         end
`ifdef SYNTH_ALLOC_SUSTAIN_EN
         sustain  <= 1'b0;
         hold     <= '0;
`endif
      end else begin
         trig     <= '0;
         steal    <= 1'b0;
         parseErr <= 1'b0;

         // Real-time bytes (0xF8-0xFF) fall through untouched.
         if (midiBus.iMidiVd && (rd < 8'hF8)) begin
            if (rd >= 8'hF0) begin
               state   <= sNoStat;
               runStat <= '0;
               inSysex <= (rd == 8'hF0);
            end else if (rd[7]) begin
               state   <= sData1;
               runStat <= rd;
               inSysex <= 1'b0;
            end else begin
               case (state)
                  sNoStat: parseErr <= !inSysex;
                  sData1: begin
                     d1Reg <= rd[6:0];
                     if (!oneByte) state <= sData2;
                  end
                  sData2:  state <= sData1;
                  default: state <= sNoStat;
               endcase
            end
         end

         if (iVoiceClr) begin
            gate <= '0;
`ifdef SYNTH_ALLOC_SUSTAIN_EN
            sustain <= 1'b0;
            hold    <= '0;
`endif
         end else if (noteOnEv) begin
            note[chosenIdx] <= msgD1;
            vel[chosenIdx]  <= msgD2;
            gate[chosenIdx] <= 1'b1;
            trig[chosenIdx] <= 1'b1;
            steal           <= !anyMatch && !anyFree;
            for (int i = 0; i < pVoiceNum; i++) begin
               if (pRankWidth'(i) == chosenIdx) rank[i] <= '0;
               else if (rank[i] < chosenRank) rank[i] <= rank[i] + 1'b1;
            end
`ifdef SYNTH_ALLOC_SUSTAIN_EN
            hold[chosenIdx] <= 1'b0;
`endif
         end else if (noteOffEv) begin
`ifdef SYNTH_ALLOC_SUSTAIN_EN
            if (sustain) begin
               hold <= hold | matchVec;
            end else begin
               gate <= gate & ~matchVec;
               hold <= hold & ~matchVec;
            end
`else
            gate <= gate & ~matchVec;
`endif
         end
`ifdef SYNTH_ALLOC_SUSTAIN_EN
         else if (ccSusEv) begin
            if (msgD2 >= 7'd64) begin
               sustain <= 1'b1;
            end else begin
               sustain <= 1'b0;
               gate    <= gate & ~hold;
               hold    <= '0;
            end
         end
`endif
      end
   end

   for (genvar g = 0; g < pVoiceNum; g++) begin : gOut
      assign oVoiceNote[7*g +: 7] = note[g];
      assign oVoiceVel[7*g +: 7]  = vel[g];
   end

   assign oVoiceGate = gate;
   assign oVoiceTrig = trig;
   assign oSteal     = steal;
   assign oParseErr  = parseErr;

endmodule

// File: tb/tb_midi_voice_allocator.sv
// tb_midi_voice_allocator: directed MIDI byte sequences checked every cycle against a byte-buffer /
// age-queue model of the allocator, plus literal expectations at key points.
module tb_midi_voice_allocator;
   localparam int N = 4;

   logic           iCLK = 1'b0;
   logic           inRST = 1'b0;
   logic [3:0]     iMidiCh = 4'd0;
   logic           iVoiceClr = 1'b0;
   logic [N*7-1:0] oVoiceNote, oVoiceVel;
   logic [N-1:0]   oVoiceGate, oVoiceTrig;
   logic           oSteal, oParseErr;

   midi_voice_allocator_if midiBus();

   midi_voice_allocator #(.pVoiceNum(N), .pRankWidth(2), .pOmni(1'b0)) dut (
      .iCLK(iCLK), .inRST(inRST), .midiBus(midiBus), .iMidiCh(iMidiCh), .iVoiceClr(iVoiceClr),
      .oVoiceNote(oVoiceNote), .oVoiceVel(oVoiceVel), .oVoiceGate(oVoiceGate),
      .oVoiceTrig(oVoiceTrig), .oSteal(oSteal), .oParseErr(oParseErr)
   );

   always #5 iCLK = ~iCLK;

   int errors = 0;
   int checks = 0;
   bit chkEn = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: pending data bytes in a buffer, voice age as a queue (front = most recently allocated).
   logic [7:0] mRun;
   bit         mSysex;
   logic [7:0] mBuf[$];
   int         mAge[$];
   logic [6:0] mNote[N];
   logic [6:0] mVel[N];
   logic [N-1:0] mGate, mTrig, mHold;
   logic       mSteal, mErr;
   bit         mSus;

   task automatic modelReset();
      mRun = 8'h00; mSysex = 1'b0; mBuf.delete(); mAge.delete();
      for (int i = 0; i < N; i++) begin
         mNote[i] = '0; mVel[i] = '0; mAge.push_back(i);
      end
      mGate = '0; mTrig = '0; mHold = '0; mSteal = 1'b0; mErr = 1'b0; mSus = 1'b0;
   endtask

   task automatic modelAlloc(input logic [6:0] n, input logic [6:0] v);
      int sel, pos;
      sel = -1;
      for (int i = 0; i < N; i++) if (sel < 0 && mGate[i] && mNote[i] == n) sel = i;
      for (int i = 0; i < N; i++) if (sel < 0 && !mGate[i]) sel = i;
      if (sel < 0) begin
         sel = mAge[N-1];
         mSteal = 1'b1;
      end
      mNote[sel] = n; mVel[sel] = v; mGate[sel] = 1'b1; mTrig[sel] = 1'b1; mHold[sel] = 1'b0;
      pos = 0;
      for (int k = 0; k < N; k++) if (mAge[k] == sel) pos = k;
      mAge.delete(pos);
      mAge.push_front(sel);
   endtask

   task automatic modelStep(input logic [7:0] b, input logic vd, input logic clr, input logic [3:0] ch);
      logic [7:0] t0, t1;
      logic [6:0] d1, d2;
      logic [3:0] hi;
      int need;
      bit on, off, ccs;
      mTrig = '0; mSteal = 1'b0; mErr = 1'b0;
      on = 1'b0; off = 1'b0; ccs = 1'b0; d1 = '0; d2 = '0;
      if (vd && b < 8'hF8) begin
         if (b >= 8'hF0) begin
            mRun = 8'h00; mSysex = (b == 8'hF0); mBuf.delete();
         end else if (b >= 8'h80) begin
            mRun = b; mSysex = 1'b0; mBuf.delete();
         end else if (mRun == 8'h00) begin
            mErr = !mSysex;
         end else begin
            mBuf.push_back(b);
            hi = mRun[7:4];
            need = (hi == 4'hC || hi == 4'hD) ? 1 : 2;
            if (mBuf.size() == need) begin
               t0 = mBuf[0];
               t1 = (need == 2) ? mBuf[1] : 8'h00;
               d1 = t0[6:0]; d2 = t1[6:0];
               mBuf.delete();
               if (mRun[3:0] == ch) begin
                  on  = (hi == 4'h9) && (d2 != 0);
                  off = (hi == 4'h8) || ((hi == 4'h9) && (d2 == 0));
                  ccs = (hi == 4'hB) && (d1 == 7'd64);
               end
            end
         end
      end
      if (clr) begin
         mGate = '0; mSus = 1'b0; mHold = '0;
      end else if (on) begin
         modelAlloc(d1, d2);
      end else if (off) begin
         for (int i = 0; i < N; i++) begin
            if (mGate[i] && mNote[i] == d1) begin
`ifdef SYNTH_ALLOC_SUSTAIN_EN
               if (mSus) mHold[i] = 1'b1;
               else mGate[i] = 1'b0;
`else
               mGate[i] = 1'b0;
`endif
            end
         end
      end
`ifdef SYNTH_ALLOC_SUSTAIN_EN
      else if (ccs) begin
         if (d2 >= 7'd64) mSus = 1'b1;
         else begin
            mSus = 1'b0;
            mGate = mGate & ~mHold;
            mHold = '0;
         end
      end
`else
      if (ccs) mSus = 1'b0;
`endif
   endtask

   always @(posedge iCLK or negedge inRST) begin
      if (!inRST) modelReset();
      else modelStep(midiBus.iMidiRd, midiBus.iMidiVd, iVoiceClr, iMidiCh);
   end

   logic [N*7-1:0] expNote, expVel;
   always @(negedge iCLK) begin
      if (chkEn) begin
         for (int i = 0; i < N; i++) begin
            expNote[7*i +: 7] = mNote[i];
            expVel[7*i +: 7]  = mVel[i];
         end
         chk("note", 32'(oVoiceNote), 32'(expNote));
         chk("vel", 32'(oVoiceVel), 32'(expVel));
         chk("gate", 32'(oVoiceGate), 32'(mGate));
         chk("trig", 32'(oVoiceTrig), 32'(mTrig));
         chk("steal", 32'(oSteal), 32'(mSteal));
         chk("parseErr", 32'(oParseErr), 32'(mErr));
      end
   end

   task automatic sendByte(input logic [7:0] b);
      midiBus.iMidiRd = b;
      midiBus.iMidiVd = 1'b1;
      @(posedge iCLK); #1;
      midiBus.iMidiVd = 1'b0;
   endtask

   task automatic send2(input logic [7:0] a, input logic [7:0] b);
      sendByte(a); sendByte(b);
   endtask

   task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
      sendByte(a); sendByte(b); sendByte(c);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge iCLK);
      #1;
   endtask

   task automatic doReset();
      inRST = 1'b0;
      repeat (2) @(posedge iCLK);
      #1 inRST = 1'b1;
      idle(1);
   endtask

   initial begin
      midiBus.iMidiRd = 8'h00;
      midiBus.iMidiVd = 1'b0;
      doReset();
      chkEn = 1'b1;
      chk("rst_gate", 32'(oVoiceGate), 32'h0);
      chk("rst_note", 32'(oVoiceNote), 32'h0);

      // Single Note On
      send3(8'h90, 8'h3C, 8'h64);
      chk("n1_note", 32'(oVoiceNote[6:0]), 32'h3C);
      chk("n1_vel", 32'(oVoiceVel[6:0]), 32'h64);
      chk("n1_gate", 32'(oVoiceGate), 32'b0001);
      chk("n1_trig", 32'(oVoiceTrig), 32'b0001);
      idle(1);
      chk("n1_trig_end", 32'(oVoiceTrig), 32'b0000);

      // Running status, then Note Off via velocity 0
      doReset();
      send3(8'h90, 8'h3C, 8'h40);
      send2(8'h40, 8'h50);
      send2(8'h43, 8'h30);
      chk("rs_gate", 32'(oVoiceGate), 32'b0111);
      chk("rs_notes", 32'(oVoiceNote[20:0]), 32'({7'h43, 7'h40, 7'h3C}));
      send2(8'h3C, 8'h00);
      chk("rs_off_gate", 32'(oVoiceGate), 32'b0110);

      // Oldest-first stealing
      doReset();
      send3(8'h90, 8'h3C, 8'h40);
      send2(8'h3E, 8'h40);
      send2(8'h40, 8'h40);
      send2(8'h41, 8'h40);
      send2(8'h43, 8'h40);
      chk("st1_steal", 32'(oSteal), 32'h1);
      chk("st1_trig", 32'(oVoiceTrig), 32'b0001);
      chk("st1_note", 32'(oVoiceNote[6:0]), 32'h43);
      send2(8'h45, 8'h40);
      chk("st2_steal", 32'(oSteal), 32'h1);
      chk("st2_trig", 32'(oVoiceTrig), 32'b0010);
      chk("st2_note", 32'(oVoiceNote[13:7]), 32'h45);
      idle(2);

      // Retrigger the same note
      doReset();
      send3(8'h90, 8'h3C, 8'h64);
      send2(8'h3C, 8'h70);
      chk("rt_trig", 32'(oVoiceTrig), 32'b0001);
      chk("rt_gate", 32'(oVoiceGate), 32'b0001);
      chk("rt_vel", 32'(oVoiceVel[6:0]), 32'h70);

      // Real-time interleave, orphan data byte, wrong channel, then matching channel
      doReset();
      sendByte(8'h90); sendByte(8'h3C); sendByte(8'hF8); sendByte(8'h64);
      chk("rtm_gate", 32'(oVoiceGate), 32'b0001);
      doReset();
      sendByte(8'h3C);
      chk("orph_err", 32'(oParseErr), 32'h1);
      chk("orph_gate", 32'(oVoiceGate), 32'h0);
      send3(8'h91, 8'h3C, 8'h64);
      chk("ch_ign_gate", 32'(oVoiceGate), 32'h0);
      iMidiCh = 4'd1;
      send2(8'h3C, 8'h64);
      chk("ch_ok_gate", 32'(oVoiceGate), 32'b0001);
      iMidiCh = 4'd0;

      // SysEx payload is silent; data after end of SysEx is an error
      doReset();
      send3(8'hF0, 8'h01, 8'h02);
      chk("sx_err", 32'(oParseErr), 32'h0);
      send2(8'hF7, 8'h3C);
      chk("sx_end_err", 32'(oParseErr), 32'h1);

      // One-byte messages, abandoned partial message
      doReset();
      send2(8'hC0, 8'h05);
      sendByte(8'h06);
      send2(8'h90, 8'h3C);
      sendByte(8'h80);
      chk("abd_err", 32'(oParseErr), 32'h0);
      send2(8'h3C, 8'h40);
      send3(8'h90, 8'h3C, 8'h64);
      chk("abd_gate", 32'(oVoiceGate), 32'b0001);
      send3(8'h80, 8'h3C, 8'h00);
      chk("abd_off_gate", 32'(oVoiceGate), 32'b0000);

      // All-notes-off wins over a simultaneous Note On
      doReset();
      send3(8'h90, 8'h3C, 8'h64);
      send2(8'h3E, 8'h64);
      sendByte(8'h40);
      iVoiceClr = 1'b1;
      sendByte(8'h64);
      iVoiceClr = 1'b0;
      chk("clr_gate", 32'(oVoiceGate), 32'h0);
      chk("clr_trig", 32'(oVoiceTrig), 32'h0);
      send2(8'h41, 8'h64);
      chk("clr_next_trig", 32'(oVoiceTrig), 32'b0001);

      // Sustain pedal (decoded only when the option is built)
      doReset();
      send3(8'hB0, 8'h40, 8'h7F);
      send3(8'h90, 8'h3C, 8'h64);
      send3(8'h90, 8'h3C, 8'h00);
`ifdef SYNTH_ALLOC_SUSTAIN_EN
      chk("sus_hold_gate", 32'(oVoiceGate), 32'b0001);
`else
      chk("sus_hold_gate", 32'(oVoiceGate), 32'b0000);
`endif
      send3(8'hB0, 8'h40, 8'h00);
      chk("sus_rel_gate", 32'(oVoiceGate), 32'b0000);
      send3(8'h90, 8'h3E, 8'h64);
      send3(8'hB0, 8'h40, 8'h7F);
      send3(8'h90, 8'h3E, 8'h00);
      iVoiceClr = 1'b1;
      idle(1);
      iVoiceClr = 1'b0;
      chk("sus_clr_gate", 32'(oVoiceGate), 32'b0000);
      send3(8'h90, 8'h40, 8'h64);
      send2(8'h40, 8'h00);
      chk("sus_after_clr", 32'(oVoiceGate), 32'b0000);
      idle(3);

      chkEn = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/midi_voice_allocator.md
Name: midi_voice_allocator

Overview:
- Sequences the synthesizer voice datapath from the MIDI byte stream produced by the UART receiver (8-bit data plus valid strobe).
- Parses channel-voice messages with running status and allocates Note On/Off events to a pool of pVoiceNum voices.
- Stealing is oldest-first when all voices are busy.
- Outputs per-voice note, velocity, gate and trigger for the oscillator/envelope stage feeding the I2S encoder; sits in the system clock domain beside the CSR block.

Parameters:
pVoiceNum, 4, number of voices (2..16)
pRankWidth, 2, width of per-voice age rank; must equal clog2(pVoiceNum)
pOmni, 0, 1 = accept all channels; 0 = accept only iMidiCh

Ports:
iCLK  in  1  system clock
inRST  in  1  asynchronous active-low reset
iMidiRd  in  8  received MIDI byte
iMidiVd  in  1  one-cycle strobe, iMidiRd valid
iMidiCh  in  4  receive channel (from CSR), ignored when pOmni=1
iVoiceClr  in  1  synchronous all-notes-off request (level, from CSR)
oVoiceNote  out  pVoiceNum*7  note number, voice i at [7i+6:7i]
oVoiceVel  out  pVoiceNum*7  velocity, voice i at [7i+6:7i]
oVoiceGate  out  pVoiceNum  1 = voice held
oVoiceTrig  out  pVoiceNum  one-cycle pulse on (re)allocation
oSteal  out  1  one-cycle pulse when a busy voice was stolen
oParseErr  out  1  one-cycle pulse on data byte with no running status

Behaviour:
- Reset (inRST=0, asynchronous): all outputs 0; parser state to sNoStat; running status cleared; voice i rank = i.
- Byte classes:
  - 0xF8-0xFF real-time: ignored, no state change.
  - 0xF0-0xF7: clears running status, enters sNoStat; bytes following 0xF0 are discarded until the next status byte.
  - 0x80-0xEF: latch running status, enter sData1.
- Data count: 1 data byte for 0xCn/0xDn, 2 for all other channel messages.
- Parser FSM:
  - sNoStat: a data byte (<0x80) pulses oParseErr (unless inside SysEx) and stays.
  - sData1: latch byte as D1; if the message has 1 data byte, complete and stay in sData1 (running status); else go to sData2.
  - sData2: latch D2, complete, return to sData1.
- A new status byte in sData2 abandons the partial message without error.
- Only completed 0x8n/0x9n messages on the accepted channel reach the allocator; 0x9n with D2=0 is treated as Note Off.
- Latency: voice outputs and pulses update on the cycle after the iMidiVd carrying the final data byte.
- Note On (D1=n, D2=v), first match wins:
  - (a) a voice with gate=1 and note=n exists: retrigger that voice, update vel.
  - (b) else the lowest-index voice with gate=0.
  - (c) else the voice with rank pVoiceNum-1; oSteal=1.
  - Chosen voice: note=n, vel=v, gate=1, trig=1.
- Rank update: chosen voice rank becomes 0; every voice whose rank < the chosen voice's old rank increments by 1. Ranks always form a permutation of 0..pVoiceNum-1.
- Note Off n: every voice with gate=1 and note=n clears its gate; note, vel and rank are held; no trig.
- iVoiceClr=1: all gates cleared that cycle. It has priority over a simultaneous completed Note On, which is dropped. Parser state is unaffected.
- Velocity is D2[6:0]; data bytes are always 7-bit, so no masking of D1 beyond [6:0] is needed.
- Back-to-back bytes on consecutive cycles are supported: allocation completes in one cycle, no backpressure.

Optional Feature:
- Macro: SYNTH_ALLOC_SUSTAIN_EN.
- Defined: parser decodes Control Change 0xBn controller 64.
  - Value >= 64 sets the sustain flag.
  - While sustained, Note Off sets a per-voice hold bit instead of clearing the gate.
  - Pedal release (value < 64) clears the gates of all held voices on the next cycle, then clears the hold bits.
  - Retrigger or steal clears that voice's hold bit; iVoiceClr clears sustain and all holds.
- Undefined: CC messages are parsed for byte counting only; no sustain logic is synthesized.

Test Plan:
- Reset, then bytes 0x90,0x3C,0x64 with iMidiCh=0 -> next cycle voice0 note=0x3C, vel=0x64, gate=1, trig0 pulse; other voices gate=0.
- Running status: 0x90,0x3C,0x40,0x40,0x50,0x43,0x30 -> voices 0,1,2 gated with notes 0x3C,0x40,0x43; then 0x3C,0x00 -> voice0 gate=0, voice1/2 unchanged.
- Steal with pVoiceNum=4: Note On 60,62,64,65, then 67 -> voice0 (oldest) gets 67, oSteal=1; then Note On 69 -> voice1 stolen.
- Retrigger: Note On 60 twice -> second event hits the same voice, trig pulses again, gate stays 1, no other voice allocated.
- Interleave: 0x90,0x3C,0xF8,0x64 -> real-time ignored, voice0 gated; 0x3C alone after reset -> oParseErr pulse, no voice change; Note On on channel 1 with iMidiCh=0, pOmni=0 -> ignored.
- SYNTH_ALLOC_SUSTAIN_EN: 0xB0,64,127; Note On 60; Note Off 60 -> gate stays 1; 0xB0,64,0 -> gate=0 next cycle; iVoiceClr pulse mid-stream -> all gates 0.
